// File: rtl/hc153_scan_ctrl.sv
// Scan sequencer for an HC153 dual 4-to-1 selector: walks all four select codes,
// samples Y1/Y2 after a settle time and publishes two 4-bit words at once.
module hc153_scan_ctrl #(
    parameter int SETTLE = 1,
    parameter bit AUTO   = 1'b0
) (
    input  logic       CP,
    input  logic       MRN,
    input  logic       START,
    input  logic       Y1,
    input  logic       Y2,
    output logic       S1,
    output logic       S2,
    output logic       E1N,
    output logic       E2N,
    output logic       BUSY,
    output logic       DONE,
    output logic [0:3] Q1,
    output logic [0:3] Q2
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // A settle time of zero is treated as one cycle; values above 15 are clamped.
    localparam int         SETTLE_EFF = (SETTLE < 1) ? 1 : ((SETTLE > 15) ? 15 : SETTLE);
    localparam logic [3:0] CNT_LAST   = 4'(SETTLE_EFF - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [0:3] sh1_q, sh1_d;
    logic [0:3] sh2_q, sh2_d;
    logic [0:3] q1_q, q1_d;
    logic [0:3] q2_q, q2_d;
    logic       enN_q, enN_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        q1_d    = q1_q;
        q2_d    = q2_q;
        enN_d   = enN_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_SETTLE;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                    enN_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                sh1_d[idx_q] = Y1;
                sh2_d[idx_q] = Y2;
                if (idx_q != 2'd3) begin
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = 4'd0;
                    state_d = ST_SETTLE;
                end else begin
                    // Last channel goes straight to Q so all four bits land on one edge.
                    q1_d    = {sh1_q[0:2], Y1};
                    q2_d    = {sh2_q[0:2], Y2};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    enN_d   = 1'b1;
                    idx_d   = 2'd0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d = 1'b0;
                if (AUTO) begin
                    state_d = ST_SETTLE;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                    enN_d   = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CP) begin
        if (!MRN) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            sh1_q   <= 4'd0;
            sh2_q   <= 4'd0;
            q1_q    <= 4'd0;
            q2_q    <= 4'd0;
            enN_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            q1_q    <= q1_d;
            q2_q    <= q2_d;
            enN_q   <= enN_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // idx is forced to zero outside a scan, so it can drive the select lines directly.
    assign S1   = idx_q[1];
    assign S2   = idx_q[0];
    assign E1N  = enN_q;
    assign E2N  = enN_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign Q1   = q1_q;
    assign Q2   = q2_q;

endmodule

// File: tb/tb_hc153_scan_ctrl.sv
// Directed bench for hc153_scan_ctrl: four instances (SETTLE=1, 3, 0 single-shot and
// SETTLE=1 auto) each wired to a behavioural HC153 model.
module tb_hc153_scan_ctrl;

    logic CP = 1'b0;
    always #5 CP = ~CP;

    int testsRun    = 0;
    int testsFailed = 0;

    // Instance A: SETTLE=1, AUTO=0
    logic mrnA, startA, y1A, y2A, s1A, s2A, e1nA, e2nA, busyA, doneA, glitchA;
    logic [0:3] q1A, q2A, in1A, in2A;
    // Instance B: SETTLE=3, AUTO=0
    logic mrnB, startB, y1B, y2B, s1B, s2B, e1nB, e2nB, busyB, doneB;
    logic [0:3] q1B, q2B, in1B, in2B;
    // Instance C: SETTLE=1, AUTO=1
    logic mrnC, startC, y1C, y2C, s1C, s2C, e1nC, e2nC, busyC, doneC;
    logic [0:3] q1C, q2C, in1C, in2C;
    // Instance D: SETTLE=0 (behaves as 1), AUTO=0
    logic mrnD, startD, y1D, y2D, s1D, s2D, e1nD, e2nD, busyD, doneD;
    logic [0:3] q1D, q2D, in1D, in2D;

    // Selector model: disabled sections output low; glitchA inverts Y1 of instance A.
    assign y1A = e1nA ? 1'b0 : (in1A[{s1A, s2A}] ^ glitchA);
    assign y2A = e2nA ? 1'b0 : in2A[{s1A, s2A}];
    assign y1B = e1nB ? 1'b0 : in1B[{s1B, s2B}];
    assign y2B = e2nB ? 1'b0 : in2B[{s1B, s2B}];
    assign y1C = e1nC ? 1'b0 : in1C[{s1C, s2C}];
    assign y2C = e2nC ? 1'b0 : in2C[{s1C, s2C}];
    assign y1D = e1nD ? 1'b0 : in1D[{s1D, s2D}];
    assign y2D = e2nD ? 1'b0 : in2D[{s1D, s2D}];

    hc153_scan_ctrl #(.SETTLE(1), .AUTO(1'b0)) uA (
        .CP(CP), .MRN(mrnA), .START(startA), .Y1(y1A), .Y2(y2A),
        .S1(s1A), .S2(s2A), .E1N(e1nA), .E2N(e2nA), .BUSY(busyA), .DONE(doneA),
        .Q1(q1A), .Q2(q2A));
    hc153_scan_ctrl #(.SETTLE(3), .AUTO(1'b0)) uB (
        .CP(CP), .MRN(mrnB), .START(startB), .Y1(y1B), .Y2(y2B),
        .S1(s1B), .S2(s2B), .E1N(e1nB), .E2N(e2nB), .BUSY(busyB), .DONE(doneB),
        .Q1(q1B), .Q2(q2B));
    hc153_scan_ctrl #(.SETTLE(1), .AUTO(1'b1)) uC (
        .CP(CP), .MRN(mrnC), .START(startC), .Y1(y1C), .Y2(y2C),
        .S1(s1C), .S2(s2C), .E1N(e1nC), .E2N(e2nC), .BUSY(busyC), .DONE(doneC),
        .Q1(q1C), .Q2(q2C));
    hc153_scan_ctrl #(.SETTLE(0), .AUTO(1'b0)) uD (
        .CP(CP), .MRN(mrnD), .START(startD), .Y1(y1D), .Y2(y2D),
        .S1(s1D), .S2(s2D), .E1N(e1nD), .E2N(e2nD), .BUSY(busyD), .DONE(doneD),
        .Q1(q1D), .Q2(q2D));

    // Status vectors are {S1,S2,E1N,E2N,BUSY,DONE}.
    localparam logic [5:0] IDLE_ST = 6'b00_11_00;
    localparam logic [5:0] DONE_ST = 6'b00_11_01;

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic test_reset();
        mrnA = 1'b0; mrnB = 1'b0; mrnC = 1'b0; mrnD = 1'b0;
        tick();
        tick();
        testsRun++;
        if ({s1A, s2A, e1nA, e2nA, busyA, doneA} !== IDLE_ST || q1A !== 4'b0 || q2A !== 4'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset A: got %b q %b %b expected %b q 0000 0000",
                     {s1A, s2A, e1nA, e2nA, busyA, doneA}, q1A, q2A, IDLE_ST);
        end
        testsRun++;
        if ({s1B, s2B, e1nB, e2nB, busyB, doneB} !== IDLE_ST || q1B !== 4'b0 || q2B !== 4'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset B: got %b q %b %b expected %b q 0000 0000",
                     {s1B, s2B, e1nB, e2nB, busyB, doneB}, q1B, q2B, IDLE_ST);
        end
        testsRun++;
        if ({s1C, s2C, e1nC, e2nC, busyC, doneC} !== IDLE_ST || q1C !== 4'b0 || q2C !== 4'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset C: got %b q %b %b expected %b q 0000 0000",
                     {s1C, s2C, e1nC, e2nC, busyC, doneC}, q1C, q2C, IDLE_ST);
        end
        testsRun++;
        if ({s1D, s2D, e1nD, e2nD, busyD, doneD} !== IDLE_ST || q1D !== 4'b0 || q2D !== 4'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset D: got %b q %b %b expected %b q 0000 0000",
                     {s1D, s2D, e1nD, e2nD, busyD, doneD}, q1D, q2D, IDLE_ST);
        end
        mrnA = 1'b1; mrnB = 1'b1; mrnC = 1'b1; mrnD = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [5:0] expSt;
        in1A = 4'b1011; in2A = 4'b0110;
        startA = 1'b1;
        tick();
        startA = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c <= 8)       expSt = {2'((c - 1) / 2), 4'b0010};
            else if (c == 9)  expSt = DONE_ST;
            else              expSt = IDLE_ST;
            testsRun++;
            if ({s1A, s2A, e1nA, e2nA, busyA, doneA} !== expSt) begin
                testsFailed++;
                $display("[TB] FAIL basic status c=%0d: got %b expected %b",
                         c, {s1A, s2A, e1nA, e2nA, busyA, doneA}, expSt);
            end
            if (c == 8) begin
                testsRun++;
                if (q1A !== 4'b0000 || q2A !== 4'b0000) begin
                    testsFailed++;
                    $display("[TB] FAIL basic q before done: got %b %b expected 0000 0000", q1A, q2A);
                end
            end
            if (c == 9) begin
                testsRun++;
                if (q1A !== 4'b1011 || q2A !== 4'b0110) begin
                    testsFailed++;
                    $display("[TB] FAIL basic q: got %b %b expected 1011 0110", q1A, q2A);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_scan();
        int doneCount;
        in1A = 4'b1011; in2A = 4'b0110;
        startA = 1'b1;
        tick();
        startA = 1'b0;
        repeat (4) tick();
        mrnA = 1'b0;
        tick();
        testsRun++;
        if ({s1A, s2A, e1nA, e2nA, busyA, doneA} !== IDLE_ST || q1A !== 4'b0 || q2A !== 4'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset state: got %b q %b %b expected %b q 0000 0000",
                     {s1A, s2A, e1nA, e2nA, busyA, doneA}, q1A, q2A, IDLE_ST);
        end
        mrnA = 1'b1;
        doneCount = 0;
        for (int c = 0; c < 12; c++) begin
            if (doneA === 1'b1) doneCount++;
            tick();
        end
        testsRun++;
        if (doneCount != 0) begin
            testsFailed++;
            $display("[TB] FAIL midreset done pulses: got %0d expected 0", doneCount);
        end
        startA = 1'b1;
        tick();
        startA = 1'b0;
        repeat (8) tick();
        testsRun++;
        if ({s1A, s2A, e1nA, e2nA, busyA, doneA} !== DONE_ST || q1A !== 4'b1011 || q2A !== 4'b0110) begin
            testsFailed++;
            $display("[TB] FAIL midreset rescan: got %b q %b %b expected %b q 1011 0110",
                     {s1A, s2A, e1nA, e2nA, busyA, doneA}, q1A, q2A, DONE_ST);
        end
        tick();
    endtask

    task automatic test_start_busy();
        int doneCount;
        in1A = 4'b0101; in2A = 4'b1100;
        startA = 1'b1;
        tick();
        startA = 1'b0;
        doneCount = 0;
        for (int c = 1; c <= 12; c++) begin
            startA = (c == 4);
            if (doneA === 1'b1) doneCount++;
            if (c == 9) begin
                testsRun++;
                if (busyA !== 1'b0 || q1A !== 4'b0101 || q2A !== 4'b1100) begin
                    testsFailed++;
                    $display("[TB] FAIL startbusy c9: got busy %b q %b %b expected busy 0 q 0101 1100",
                             busyA, q1A, q2A);
                end
            end
            if (c == 10) begin
                testsRun++;
                if (busyA !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL startbusy c10 busy: got %b expected 0", busyA);
                end
            end
            tick();
        end
        startA = 1'b0;
        testsRun++;
        if (doneCount != 1) begin
            testsFailed++;
            $display("[TB] FAIL startbusy done pulses: got %0d expected 1", doneCount);
        end
    endtask

    task automatic test_start_held();
        in1A = 4'b1110; in2A = 4'b0001;
        startA = 1'b1;
        tick();
        for (int c = 1; c <= 11; c++) begin
            if (c == 9) begin
                testsRun++;
                if ({s1A, s2A, e1nA, e2nA, busyA, doneA} !== DONE_ST || q1A !== 4'b1110 || q2A !== 4'b0001) begin
                    testsFailed++;
                    $display("[TB] FAIL held c9: got %b q %b %b expected %b q 1110 0001",
                             {s1A, s2A, e1nA, e2nA, busyA, doneA}, q1A, q2A, DONE_ST);
                end
            end
            if (c == 10) begin
                testsRun++;
                if ({s1A, s2A, e1nA, e2nA, busyA, doneA} !== IDLE_ST) begin
                    testsFailed++;
                    $display("[TB] FAIL held c10 idle: got %b expected %b",
                             {s1A, s2A, e1nA, e2nA, busyA, doneA}, IDLE_ST);
                end
            end
            if (c == 11) begin
                testsRun++;
                if ({s1A, s2A, e1nA, e2nA, busyA, doneA} !== 6'b00_00_10) begin
                    testsFailed++;
                    $display("[TB] FAIL held c11 restart: got %b expected 000010",
                             {s1A, s2A, e1nA, e2nA, busyA, doneA});
                end
            end
            tick();
        end
        startA = 1'b0;
        repeat (10) tick();
        testsRun++;
        if ({s1A, s2A, e1nA, e2nA, busyA, doneA} !== IDLE_ST) begin
            testsFailed++;
            $display("[TB] FAIL held settle idle: got %b expected %b",
                     {s1A, s2A, e1nA, e2nA, busyA, doneA}, IDLE_ST);
        end
    endtask

    task automatic test_glitch();
        in1A = 4'b0110; in2A = 4'b1001;
        startA = 1'b1;
        tick();
        startA = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            glitchA = (c % 2 == 1) && (c <= 8);
            if (c == 9) begin
                testsRun++;
                if (doneA !== 1'b1 || q1A !== 4'b0110 || q2A !== 4'b1001) begin
                    testsFailed++;
                    $display("[TB] FAIL glitch q: got done %b q %b %b expected done 1 q 0110 1001",
                             doneA, q1A, q2A);
                end
            end
            tick();
        end
        glitchA = 1'b0;
    endtask

    task automatic test_settle3();
        logic [5:0] expSt;
        in1B = 4'b1011; in2B = 4'b0110;
        startB = 1'b1;
        tick();
        startB = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            if (c <= 16)      expSt = {2'((c - 1) / 4), 4'b0010};
            else if (c == 17) expSt = DONE_ST;
            else              expSt = IDLE_ST;
            testsRun++;
            if ({s1B, s2B, e1nB, e2nB, busyB, doneB} !== expSt) begin
                testsFailed++;
                $display("[TB] FAIL settle3 status c=%0d: got %b expected %b",
                         c, {s1B, s2B, e1nB, e2nB, busyB, doneB}, expSt);
            end
            if (c == 17) begin
                testsRun++;
                if (q1B !== 4'b1011 || q2B !== 4'b0110) begin
                    testsFailed++;
                    $display("[TB] FAIL settle3 q: got %b %b expected 1011 0110", q1B, q2B);
                end
            end
            tick();
        end
    endtask

    task automatic test_settle0();
        logic [5:0] expSt;
        in1D = 4'b0011; in2D = 4'b1010;
        startD = 1'b1;
        tick();
        startD = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c <= 8)       expSt = {2'((c - 1) / 2), 4'b0010};
            else if (c == 9)  expSt = DONE_ST;
            else              expSt = IDLE_ST;
            testsRun++;
            if ({s1D, s2D, e1nD, e2nD, busyD, doneD} !== expSt) begin
                testsFailed++;
                $display("[TB] FAIL settle0 status c=%0d: got %b expected %b",
                         c, {s1D, s2D, e1nD, e2nD, busyD, doneD}, expSt);
            end
            if (c == 9) begin
                testsRun++;
                if (q1D !== 4'b0011 || q2D !== 4'b1010) begin
                    testsFailed++;
                    $display("[TB] FAIL settle0 q: got %b %b expected 0011 1010", q1D, q2D);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] expSt;
        int p;
        in1C = 4'b1011; in2C = 4'b0110;
        startC = 1'b1;
        tick();
        startC = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            if (c == 3) in1C = 4'b0001;
            p = ((c - 1) % 9) + 1;
            if (p <= 8) expSt = {2'((p - 1) / 2), 4'b0010};
            else        expSt = DONE_ST;
            testsRun++;
            if ({s1C, s2C, e1nC, e2nC, busyC, doneC} !== expSt) begin
                testsFailed++;
                $display("[TB] FAIL auto status c=%0d: got %b expected %b",
                         c, {s1C, s2C, e1nC, e2nC, busyC, doneC}, expSt);
            end
            if (c == 9 || c == 17) begin
                testsRun++;
                if (q1C !== 4'b1001 || q2C !== 4'b0110) begin
                    testsFailed++;
                    $display("[TB] FAIL auto first q c=%0d: got %b %b expected 1001 0110", c, q1C, q2C);
                end
            end
            if (c == 18) begin
                testsRun++;
                if (q1C !== 4'b0001 || q2C !== 4'b0110) begin
                    testsFailed++;
                    $display("[TB] FAIL auto second q: got %b %b expected 0001 0110", q1C, q2C);
                end
            end
            tick();
        end
        mrnC = 1'b0;
        tick();
        mrnC = 1'b1;
    endtask

    initial begin
        mrnA = 1'b0; mrnB = 1'b0; mrnC = 1'b0; mrnD = 1'b0;
        startA = 1'b0; startB = 1'b0; startC = 1'b0; startD = 1'b0;
        in1A = 4'b0; in2A = 4'b0; in1B = 4'b0; in2B = 4'b0;
        in1C = 4'b0; in2C = 4'b0; in1D = 4'b0; in2D = 4'b0;
        glitchA = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_reset_mid_scan();
        test_start_busy();
        test_start_held();
        test_glitch();
        test_settle3();
        test_settle0();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
